// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
//   Shared definitions for the multi-sprite renderer:
//     - bit positions of R/G/B/A inside a 4-bit sprite pixel nibble
//     - fetch FSM state encoding
//     - coord_slice(): extracts sprite idx's coordinate from a packed vector
//   No ports (package).
// ----------------------------------------------------------------------------
package sprite_pkg;

    localparam int PIX_R = 3;
    localparam int PIX_G = 2;
    localparam int PIX_B = 1;
    localparam int PIX_A = 0;

    // Widest coordinate and largest sprite count the helper supports.
    localparam int COORD_MAX_W = 16;
    localparam int COORD_VEC_W = 8 * COORD_MAX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAPT = 2'd2
    } fetch_state_t;

    // Sprite idx occupies vec[idx*pos_w +: pos_w]; callers zero-extend their
    // packed vector to COORD_VEC_W and truncate the result to their width.
    function automatic logic [COORD_MAX_W-1:0] coord_slice(
        input logic [COORD_VEC_W-1:0] vec,
        input int                     idx,
        input int                     pos_w
    );
        logic [COORD_MAX_W-1:0] mask;
        mask = (COORD_MAX_W'(1) << pos_w) - COORD_MAX_W'(1);
        return COORD_MAX_W'(vec >> (idx * pos_w)) & mask;
    endfunction

endpackage

// File: rtl/multi_sprite_renderer_if.sv
// ----------------------------------------------------------------------------
// multi_sprite_renderer_if
//   Bitmap ROM fetch bus between the renderer (master) and the ROM (slave).
//     rom_req     1            fetch strobe, one cycle per fetch
//     rom_sprite  3            sprite index being fetched
//     rom_line    4            line within that sprite
//     rom_bits    4*SPRITE_W   bitmap line, valid the cycle after rom_req
// ----------------------------------------------------------------------------
interface multi_sprite_renderer_if #(
    parameter int SPRITE_W = 16
);
    logic                  rom_req;
    logic [2:0]            rom_sprite;
    logic [3:0]            rom_line;
    logic [4*SPRITE_W-1:0] rom_bits;

    modport master (
        output rom_req,
        output rom_sprite,
        output rom_line,
        input  rom_bits
    );

    modport slave (
        input  rom_req,
        input  rom_sprite,
        input  rom_line,
        output rom_bits
    );
endinterface

// File: rtl/sprite_line_slot.sv
// ----------------------------------------------------------------------------
// sprite_line_slot
//   Holds one sprite's bitmap line for the next scanline plus its hit bit, and
//   evaluates that sprite's pixel at the current hpos.
//   Ports:
//     clk, reset      pixel clock, synchronous active-high reset
//     i_load          capture i_bits into the line buffer and set hit
//     i_clear         clear hit (sprite not on the next line)
//     i_bits          bitmap line from the ROM, pixel 0 in the MSB nibble
//     i_hpos          current pixel column
//     i_x             sprite X position
//     i_display_on    active-video flag
//     o_opaque        sprite covers this pixel and its alpha bit is set
//     o_rgb           {R,G,B} of the covered pixel (meaningful when o_opaque)
// ----------------------------------------------------------------------------
module sprite_line_slot
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int POS_W    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [4*SPRITE_W-1:0] i_bits,
    input  logic [POS_W-1:0]      i_hpos,
    input  logic [POS_W-1:0]      i_x,
    input  logic                  i_display_on,
    output logic                  o_opaque,
    output logic [2:0]            o_rgb
);

    logic [4*SPRITE_W-1:0] r_buf;
    logic                  r_hit;
    logic [POS_W-1:0]      w_col;
    logic                  w_covering;
    logic [3:0]            w_nib;

    // Constant-index selection keeps every slice in range even when col is
    // outside the sprite; the result is then masked by w_covering.
    function automatic logic [3:0] pick_nibble(
        input logic [4*SPRITE_W-1:0] bits,
        input logic [POS_W-1:0]      col
    );
        logic [3:0] nib;
        nib = 4'b0;
        for (int c = 0; c < SPRITE_W; c++) begin
            if (col == POS_W'(c)) begin
                nib = bits[4*(SPRITE_W-1-c) +: 4];
            end
        end
        return nib;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
            r_hit <= 1'b0;
        end else if (i_load) begin
            r_buf <= i_bits;
            r_hit <= 1'b1;
        end else if (i_clear) begin
            r_hit <= 1'b0;
        end
    end

    // Modular subtraction: a sprite with x near 2^POS_W enters from the left.
    assign w_col      = i_hpos - i_x;
    assign w_covering = r_hit && (w_col < POS_W'(SPRITE_W)) && i_display_on;
    assign w_nib      = pick_nibble(r_buf, w_col);
    assign o_opaque   = w_covering && w_nib[PIX_A];
    assign o_rgb      = {w_nib[PIX_R], w_nib[PIX_G], w_nib[PIX_B]};

endmodule

// File: rtl/multi_sprite_renderer.sv
// ----------------------------------------------------------------------------
// multi_sprite_renderer
//   Composites NUM_SPRITES bitmap sprites onto the scanline with fixed
//   priority (index 0 on top). During horizontal blanking a fetch FSM reads
//   each sprite's bitmap line for the next scanline from the shared ROM.
//   Ports:
//     clk, reset              pixel clock, synchronous active-high reset
//     hpos, vpos              beam position from hvsync_generator
//     display_on              active-video flag
//     line_start              one-cycle pulse at start of hblank
//     frame_start             one-cycle pulse per frame, clears collisions
//     sprite_en/x/y           per-sprite enable and packed positions
//     rom                     bitmap ROM fetch bus (master side)
//     red/green/blue/alpha    registered composited pixel
//     collision               sticky per-sprite overlap flags
//     busy                    fetch sequence in progress
// ----------------------------------------------------------------------------
module multi_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int POS_W       = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [POS_W-1:0]             hpos,
    input  logic [POS_W-1:0]             vpos,
    input  logic                         display_on,
    input  logic                         line_start,
    input  logic                         frame_start,
    input  logic [NUM_SPRITES-1:0]       sprite_en,
    input  logic [NUM_SPRITES*POS_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*POS_W-1:0] sprite_y,
    multi_sprite_renderer_if.master      rom,
    output logic                         red,
    output logic                         green,
    output logic                         blue,
    output logic                         alpha,
    output logic [NUM_SPRITES-1:0]       collision,
    output logic                         busy
);

    fetch_state_t r_state, w_state_nxt;
    logic [2:0]   r_idx, w_idx_nxt;

    logic [7:0]       w_en8;
    logic [POS_W-1:0] w_y_cur;
    logic [POS_W-1:0] w_off;
    logic             w_hit_cur;
    logic             w_last;

    logic [NUM_SPRITES-1:0]      w_load;
    logic [NUM_SPRITES-1:0]      w_clear;
    logic [NUM_SPRITES-1:0]      w_opaque;
    logic [NUM_SPRITES-1:0][2:0] w_rgb;

    logic       w_any;
    logic [2:0] w_rgb_sel;
    logic [3:0] w_cnt;
    logic       w_multi;

    logic                   r_red, r_green, r_blue, r_alpha;
    logic [NUM_SPRITES-1:0] r_coll;

    // Sprite currently addressed by the fetch FSM. Fetched data is for the
    // next line, hence vpos+1 (wrapping on the last line).
    assign w_en8     = 8'(sprite_en);
    assign w_y_cur   = POS_W'(coord_slice(COORD_VEC_W'(sprite_y), int'(r_idx), POS_W));
    assign w_off     = vpos + POS_W'(1) - w_y_cur;
    assign w_hit_cur = w_en8[r_idx] && (w_off < POS_W'(SPRITE_H));
    assign w_last    = (r_idx == 3'(NUM_SPRITES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        rom.rom_req    = 1'b0;
        rom.rom_sprite = 3'd0;
        rom.rom_line   = 4'd0;
        // A new line_start always restarts the sequence from sprite 0 and
        // suppresses any request or capture of the interrupted step.
        if (line_start) begin
            w_state_nxt = ST_REQ;
            w_idx_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                end
                ST_REQ: begin
                    if (w_hit_cur) begin
                        rom.rom_req    = 1'b1;
                        rom.rom_sprite = r_idx;
                        rom.rom_line   = w_off[3:0];
                        w_state_nxt    = ST_CAPT;
                    end else if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
                ST_CAPT: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_REQ;
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_REQ) || (r_state == ST_CAPT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
            assign w_load[gi]  = (r_state == ST_CAPT) && (r_idx == 3'(gi)) && !line_start;
            assign w_clear[gi] = (r_state == ST_REQ) && (r_idx == 3'(gi)) && !w_hit_cur
                                 && !line_start;

            sprite_line_slot #(
                .SPRITE_W (SPRITE_W),
                .POS_W    (POS_W)
            ) u_slot (
                .clk          (clk),
                .reset        (reset),
                .i_load       (w_load[gi]),
                .i_clear      (w_clear[gi]),
                .i_bits       (rom.rom_bits),
                .i_hpos       (hpos),
                .i_x          (POS_W'(coord_slice(COORD_VEC_W'(sprite_x), gi, POS_W))),
                .i_display_on (display_on),
                .o_opaque     (w_opaque[gi]),
                .o_rgb        (w_rgb[gi])
            );
        end
    endgenerate

    // Walk from lowest to highest priority so sprite 0 wins the final write.
    always_comb begin
        w_any     = 1'b0;
        w_rgb_sel = 3'b0;
        w_cnt     = 4'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_any     = 1'b1;
                w_rgb_sel = w_rgb[i];
                w_cnt     = w_cnt + 4'd1;
            end
        end
    end

    assign w_multi = (w_cnt >= 4'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red   <= 1'b0;
            r_green <= 1'b0;
            r_blue  <= 1'b0;
            r_alpha <= 1'b0;
            r_coll  <= '0;
        end else begin
            r_red   <= w_rgb_sel[2];
            r_green <= w_rgb_sel[1];
            r_blue  <= w_rgb_sel[0];
            r_alpha <= w_any;
            // frame_start wipes old flags but never a collision seen this cycle.
            r_coll  <= (frame_start ? '0 : r_coll) | (w_multi ? w_opaque : '0);
        end
    end

    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;
    assign alpha     = r_alpha;
    assign collision = r_coll;

endmodule

// File: doc/multi_sprite_renderer.md
Name: multi_sprite_renderer

Overview:
- Parametrised successor to the single-sprite renderer: composites NUM_SPRITES bitmap sprites onto the VGA scanline with fixed priority.
- Fetches each sprite's next-line bitmap from a shared bitmap ROM port during horizontal blanking.
- Raises sticky per-sprite collision flags for game logic.
- Sits between hvsync_generator, the sprite bitmap ROM, and the final RGB output register in the top level.

Parameters:
- NUM_SPRITES, 4: number of sprites, 1..8; index 0 has highest priority.
- SPRITE_W, 16: sprite width in pixels, 1..16.
- SPRITE_H, 16: sprite height in lines, 1..16.
- POS_W, 10: width of hpos/vpos/sprite coordinates.

Ports:
- clk  in  1  pixel clock (PLL output).
- reset  in  1  synchronous, active-high reset.
- hpos  in  POS_W  current pixel column from hvsync_generator.
- vpos  in  POS_W  current line from hvsync_generator.
- display_on  in  1  active-video flag.
- line_start  in  1  one-cycle pulse at start of horizontal blanking.
- frame_start  in  1  one-cycle pulse once per frame.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_x  in  NUM_SPRITES*POS_W  packed X positions; sprite i at [i*POS_W +: POS_W].
- sprite_y  in  NUM_SPRITES*POS_W  packed Y positions; same packing.
- rom_req  out  1  bitmap fetch strobe.
- rom_sprite  out  3  sprite index for the fetch.
- rom_line  out  4  line within the sprite.
- rom_bits  in  4*SPRITE_W  bitmap data, valid the cycle after rom_req.
- red, green, blue, alpha  out  1 each  composited pixel, registered.
- collision  out  NUM_SPRITES  sticky overlap flags.
- busy  out  1  fetch sequence in progress.

Behaviour:
- Reset: every output is 0. All line buffers are cleared. All hit bits are 0. Fetch FSM is in IDLE. Collision flags are 0.
- Fetch FSM, states IDLE, REQ, CAPT:
  - IDLE -> REQ on line_start, with idx=0.
  - REQ, for sprite idx:
    - off = (vpos+1 - y[idx]) mod 2^POS_W.
    - Hit when sprite_en[idx]=1 and off < SPRITE_H.
    - On a hit: assert rom_req for exactly one cycle, with rom_sprite=idx and rom_line=off[3:0]. Go to CAPT.
    - On a miss: clear hit[idx]. Go to the next idx, or IDLE after NUM_SPRITES-1.
  - CAPT: load rom_bits into buf[idx] and set hit[idx]=1. Go to REQ with idx+1, or IDLE after the last sprite.
- Fetch timing: at most 2*NUM_SPRITES cycles, which fits within the 160-cycle hblank.
- busy=1 in REQ and CAPT.
- line_start while busy restarts the sequence at idx=0. Buffers not yet refetched keep their old contents.
- Fetched data is used on the following line (vpos+1). On the last line, vpos+1 wraps modulo 2^POS_W; vpos values never reach the wrapped range, so line 0 gets no sprites.
- Rendering, per sprite per cycle:
  - col = (hpos - x[i]) mod 2^POS_W.
  - The sprite is covering when hit[i]=1, col < SPRITE_W and display_on=1.
  - Pixel nibble = buf[i][4*(SPRITE_W-1-col) +: 4], ordered {R,G,B,A}. Pixel 0 is the MSB nibble.
  - The sprite is opaque when it is covering and A=1.
- Wrap: x near 2^POS_W wraps onto hpos 0 and up, which gives left-edge entry. Horizontal blanking clips columns beyond the visible area.
- Composition: the lowest-index opaque sprite supplies R,G,B, with alpha=1. With no opaque sprite, all four outputs are 0. display_on=0 forces all outputs to 0.
- Latency: the output reflects hpos one cycle after hpos is presented.
- Collision:
  - If two or more sprites are opaque in the same cycle, set collision[i] for every opaque sprite, on the next edge.
  - frame_start clears all flags.
  - frame_start together with a new collision in the same cycle: the new bits stay set, all others clear.
- Reset mid-fetch: the FSM returns to IDLE and rom_req deasserts on the next edge.

Decomposition:
- Shared package sprite_pkg holds:
  - pixel nibble bit positions: R=3, G=2, B=1, A=0;
  - FSM state encodings;
  - a helper for the packed-coordinate slice.
- One natural sub-module, sprite_line_slot, instantiated NUM_SPRITES times. Each instance holds buf and hit and computes the opaque and RGB outputs for one sprite.
- The top of this block contains the fetch FSM, the priority mux, the collision logic and the output register.

Test Plan:
- Single sprite: sprite0 at x=100, y=150, ROM line 0 = all nibbles 4'b1001. Pulse line_start at vpos=149. On line 150, red=1 and alpha=1 at the cycles after hpos=100..115. Outputs are 0 elsewhere, including after hpos=116.
- Priority: sprites 0 and 1 both at (200,50) with different colours, all pixels opaque. Output shows sprite 0's colour. collision=4'b0011 after the first overlapping pixel.
- Collision clear: pulse frame_start in the same cycle as a sprite 2/3 overlap, with collision=4'b0011 previously set. Result is collision=4'b1100.
- Fetch sequencing: sprites 0 and 2 hit, sprites 1 and 3 miss. rom_req pulses twice, with rom_sprite=0 then 2. busy lasts 6 cycles. rom_line equals vpos+1-y.
- Transparency, vertical bounds and wrap:
  - A=0 nibbles in sprite 0 reveal sprite 1 beneath.
  - Sprite at y=150 is absent on lines 149 and 166.
  - x=1020 draws columns 4..15 at hpos 0..11.
- Reset mid-fetch: assert reset during CAPT. Next cycle, all outputs are 0 and busy=0. The next line_start refetches normally.
